// File: rtl/sevseg_muxn.sv
// Multiplexed N-digit hex seven-segment driver.
// Each digit gets a fixed slot: a short blanking interval (ghost suppression)
// followed by the lit interval. Inputs are snapshotted once per frame so a
// frame never mixes old and new values. All display outputs are registered.
module sevseg_muxn #(
  parameter int NDIGITS      = 4,
  parameter int SLOT_CYCLES  = 48000,
  parameter int BLANK_CYCLES = 480
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic [4*NDIGITS-1:0]   digits,
  input  logic [NDIGITS-1:0]     dp,
  input  logic                   lz_en,
  output logic [6:0]             seg,
  output logic                   seg_dp,
  output logic [NDIGITS-1:0]     anode,
  output logic                   frame_done
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = $clog2(NDIGITS);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      snap;
  logic                      fd_d;

  logic [NDIGITS-1:0][3:0]   dig_snap;
  logic [NDIGITS-1:0]        dp_snap;
  logic                      lz_snap;

  logic [NDIGITS-1:0]        blank_dig;
  logic                      zero_hi;
  logic [3:0]                nib;
  logic [6:0]                seg_dec;
  logic [6:0]                seg_d;
  logic                      seg_dp_d;
  logic [NDIGITS-1:0]        anode_d;

  // Next-state: slot timing, digit index advance, snapshot and frame pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap    = 1'b0;
    fd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
          snap    = 1'b1;
        end
      end
      BLANK: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BLANK_CYCLES - 1)) state_d = SHOW;
        end
      end
      SHOW: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == CW'(SLOT_CYCLES - 1)) begin
          state_d = BLANK;
          cnt_d   = '0;
          if (idx_q == IW'(NDIGITS - 1)) begin
            idx_d = '0;
            snap  = 1'b1;
            fd_d  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // State, counter and index registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Frame snapshot; the only place the display inputs are sampled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dig_snap <= '0;
      dp_snap  <= '0;
      lz_snap  <= 1'b0;
    end else if (snap) begin
      dig_snap <= digits;
      dp_snap  <= dp;
      lz_snap  <= lz_en;
    end
  end

  // Leading-zero mask: digit i>0 blanks when it and every higher digit are 0.
  always_comb begin
    zero_hi   = 1'b1;
    blank_dig = '0;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      zero_hi      = zero_hi & (dig_snap[i] == 4'h0);
      blank_dig[i] = lz_snap & zero_hi;
    end
  end

  // Single hex decoder, fed from the snapshot of the digit about to be shown.
  always_comb begin
    nib = dig_snap[idx_d];
    case (nib)
      4'h0: seg_dec = 7'b1000000;
      4'h1: seg_dec = 7'b1111001;
      4'h2: seg_dec = 7'b0100100;
      4'h3: seg_dec = 7'b0110000;
      4'h4: seg_dec = 7'b0011001;
      4'h5: seg_dec = 7'b0010010;
      4'h6: seg_dec = 7'b0000010;
      4'h7: seg_dec = 7'b1111000;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0010000;
      4'hA: seg_dec = 7'b0001000;
      4'hB: seg_dec = 7'b0000011;
      4'hC: seg_dec = 7'b1000110;
      4'hD: seg_dec = 7'b0100001;
      4'hE: seg_dec = 7'b0000110;
      default: seg_dec = 7'b0001110;
    endcase
  end

  // Output values for the upcoming state; off unless entering/staying in SHOW.
  always_comb begin
    seg_d    = 7'h7F;
    seg_dp_d = 1'b1;
    anode_d  = '1;
    if (state_d == SHOW) begin
      anode_d  = ~(NDIGITS'(1) << idx_d);
      seg_d    = blank_dig[idx_d] ? 7'h7F : seg_dec;
      seg_dp_d = ~dp_snap[idx_d];
    end
  end

  // Registered display outputs and frame pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg        <= 7'h7F;
      seg_dp     <= 1'b1;
      anode      <= '1;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_d;
      seg_dp     <= seg_dp_d;
      anode      <= anode_d;
      frame_done <= fd_d;
    end
  end

endmodule

// File: doc/sevseg_muxn.md
SEVSEG_MUXN -- requirements
Module: sevseg_muxn

Interface
REQ-001 SHALL have parameter NDIGITS, default 4: number of multiplexed digits (legal 2..8).
REQ-002 SHALL have parameter SLOT_CYCLES, default 48000: clock cycles per digit slot (legal >= BLANK_CYCLES+2).
REQ-003 SHALL have parameter BLANK_CYCLES, default 480: ghost-suppression blanking cycles at slot start (legal >= 1).
REQ-004 SHALL have port `clk`, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port `reset_n`, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port `en`, input, 1 bit: scan enable.
REQ-007 SHALL have port `digits`, input, 4*NDIGITS bits: hex nibble per digit; digit i is bits [4i+3:4i]; digit 0 is least significant.
REQ-008 SHALL have port `dp`, input, NDIGITS bits: decimal point request per digit.
REQ-009 SHALL have port `lz_en`, input, 1 bit: leading-zero suppression enable.
REQ-010 SHALL have port `seg`, output, 7 bits: active-low segments; seg[0]=a … seg[6]=g.
REQ-011 SHALL have port `seg_dp`, output, 1 bit: active-low decimal point.
REQ-012 SHALL have port `anode`, output, NDIGITS bits: active-low digit enables.
REQ-013 SHALL have port `frame_done`, output, 1 bit: one-cycle pulse at the end of each full scan.

Function
REQ-014 SHALL contain exactly one hex-to-7-segment decoder, fed by a mux selecting the current digit's snapshot nibble.
REQ-015 Decoder SHALL use the standard hex table, active-low: 0→7'b1000000, 1→7'b1111001, 8→7'b0000000, A→7'b0001000, F→7'b0001110.
REQ-016 SHALL implement FSM states IDLE, BLANK, SHOW, held in registers, with a slot counter of width clog2(SLOT_CYCLES) and a digit index of width clog2(NDIGITS).
REQ-017 IDLE: all outputs in the off state. If en=1, next state is BLANK with index 0, slot counter 0, and a snapshot taken.
REQ-018 Snapshot: on entry to digit 0's BLANK, digits, dp and lz_en SHALL be captured into registers; these inputs SHALL be sampled at no other time, so each frame is tear-free.
REQ-019 BLANK: seg=7'h7F, seg_dp=1, anode all 1. Lasts BLANK_CYCLES cycles, then goes to SHOW.
REQ-020 SHOW: anode[idx]=0 and all other anode bits 1; seg shows the decoded snapshot nibble; seg_dp = ~dp_snap[idx]. SHOW lasts SLOT_CYCLES-BLANK_CYCLES cycles.
REQ-021 At the end of SHOW: idx increments and the FSM goes to BLANK. At idx=NDIGITS-1, idx wraps to 0, a new snapshot is taken, and frame_done=1 for exactly that one cycle.
REQ-022 Leading-zero suppression: when lz_snap=1, any digit i>0 whose snapshot nibble and all higher-index snapshot nibbles are 0 SHALL show seg=7'h7F. Its anode SHALL still assert, and dp SHALL still honour dp_snap. Digit 0 SHALL never be suppressed.
REQ-023 seg, seg_dp and anode SHALL be registered outputs, updated only on clk rising edges, with no combinational input-to-output path.
REQ-024 en falling mid-slot: on the next edge, state=IDLE, outputs off, counter and idx cleared, no frame_done pulse.
REQ-025 Each full frame SHALL be exactly NDIGITS*SLOT_CYCLES cycles; no two anode bits SHALL ever be low in the same cycle.
REQ-026 A change on digits mid-frame SHALL NOT affect any digit until the next frame.

Reset
REQ-027 While reset_n=0, outputs SHALL be: seg=7'h7F, seg_dp=1, anode all 1, frame_done=0. Internal state SHALL be: state IDLE, idx=0, counter 0, snapshot registers 0.
REQ-028 Reset SHALL take effect asynchronously at any point, including mid-SHOW. After release, operation SHALL restart per REQ-017 on the first edge with en=1.

Verification (NDIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2)
REQ-029 Basic scan: en=1, digits=16'h1234, dp=0, lz_en=0 → per slot, 2 blank cycles then 6 cycles of anode=4'b1110 with seg=7'b0011001 (4), then anode=4'b1101 (3), 4'b1011 (2), 4'b0111 (1); frame_done pulses every 32 cycles.
REQ-030 Leading zeros: digits=16'h0050, lz_en=1 → digits 3 and 2 show seg=7'h7F with anode active; digit 1 shows 5; digit 0 shows 0 (7'b1000000). Same stimulus with digits=16'h0000 → only digit 0 lit, showing 0.
REQ-031 Snapshot: change digits from 16'h1111 to 16'h2222 during digit 1's SHOW → digits 2 and 3 still show 1 in that frame; every digit shows 2 from the next frame.
REQ-032 Enable drop: deassert en during digit 2's SHOW → next cycle anode=4'b1111, seg=7'h7F, no frame_done; re-assert en → scan restarts at digit 0 after 2 blank cycles.
REQ-033 Async reset: pulse reset_n low mid-SHOW, between clock edges → outputs go off immediately, without waiting for a clock edge. The bench SHALL also check, throughout every test, that at most one anode bit is low in any cycle and that dp=4'b0100 drives seg_dp=0 only during digit 2's SHOW.
